// File: rtl/addr_decode_rt.sv
// Address decoder with a runtime-programmable rule table and registered lookup response.
// Optional decode-error counter enabled by ADDR_DECODE_RT_ERR_CNT_EN.
module addr_decode_rt #(
    parameter int unsigned NoIndices   = 32'd2,
    parameter int unsigned NoRules     = 32'd4,
    parameter int unsigned AddrWidth   = 32'd32,
    parameter int unsigned ErrCntWidth = 32'd16,
    localparam int unsigned IdxWidth   =
        (NoIndices > 32'd1) ? unsigned'($clog2(NoIndices)) : 32'd1,
    localparam int unsigned RuleWidth  =
        (NoRules > 32'd1) ? unsigned'($clog2(NoRules)) : 32'd1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cfg_we_i,
    input  logic [RuleWidth-1:0]   cfg_rule_i,
    input  logic                   cfg_en_i,
    input  logic [IdxWidth-1:0]    cfg_idx_i,
    input  logic [AddrWidth-1:0]   cfg_start_i,
    input  logic [AddrWidth-1:0]   cfg_end_i,
    output logic                   cfg_err_o,
    input  logic                   en_default_idx_i,
    input  logic [IdxWidth-1:0]    default_idx_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [AddrWidth-1:0]   req_addr_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [IdxWidth-1:0]    rsp_idx_o,
    output logic                   rsp_dec_error_o,
    input  logic                   err_cnt_clr_i,
    output logic [ErrCntWidth-1:0] err_cnt_o
);

    logic [NoRules-1:0]                en_q, en_d;
    logic [NoRules-1:0][IdxWidth-1:0]  idx_q, idx_d;
    logic [NoRules-1:0][AddrWidth-1:0] start_q, start_d;
    logic [NoRules-1:0][AddrWidth-1:0] end_q, end_d;

    logic                cfg_err_q, cfg_err_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [IdxWidth-1:0] rsp_idx_q, rsp_idx_d;
    logic                rsp_err_q, rsp_err_d;

    logic                cfg_bad;
    logic                cfg_ok;
    logic                accept;
    logic                dec_hit;
    logic [IdxWidth-1:0] dec_idx;
    logic                dec_err;

    assign cfg_bad = (32'(cfg_idx_i) >= NoIndices) ||
                     (32'(cfg_rule_i) >= NoRules);
    assign cfg_ok  = cfg_we_i && !cfg_bad;

    always_comb begin
        en_d      = en_q;
        idx_d     = idx_q;
        start_d   = start_q;
        end_d     = end_q;
        cfg_err_d = cfg_we_i && cfg_bad;
        for (int unsigned i = 0; i < NoRules; i++) begin
            if (cfg_ok && (cfg_rule_i == RuleWidth'(i))) begin
                en_d[i]    = cfg_en_i;
                idx_d[i]   = cfg_idx_i;
                start_d[i] = cfg_start_i;
                end_d[i]   = cfg_end_i;
            end
        end
    end

    // Ascending scan: a later (higher-numbered) hit overrides earlier ones.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        dec_err = 1'b0;
        for (int unsigned i = 0; i < NoRules; i++) begin
            if (en_q[i] && (start_q[i] < end_q[i]) &&
                (req_addr_i >= start_q[i]) && (req_addr_i < end_q[i])) begin
                dec_hit = 1'b1;
                dec_idx = idx_q[i];
            end
        end
        if (!dec_hit) begin
            if (en_default_idx_i) begin
                dec_idx = default_idx_i;
            end else begin
                dec_idx = '0;
                dec_err = 1'b1;
            end
        end
    end

    assign req_ready_o = !rsp_valid_q || rsp_ready_i;
    assign accept      = req_valid_i && req_ready_o;

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_idx_d   = rsp_idx_q;
        rsp_err_d   = rsp_err_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_idx_d   = dec_idx;
            rsp_err_d   = dec_err;
        end else if (rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q        <= '0;
            idx_q       <= '0;
            start_q     <= '0;
            end_q       <= '0;
            cfg_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            en_q        <= en_d;
            idx_q       <= idx_d;
            start_q     <= start_d;
            end_q       <= end_d;
            cfg_err_q   <= cfg_err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_idx_q   <= rsp_idx_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cfg_err_o       = cfg_err_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_idx_o       = rsp_idx_q;
    assign rsp_dec_error_o = rsp_err_q;

`ifdef ADDR_DECODE_RT_ERR_CNT_EN
    logic [ErrCntWidth-1:0] err_cnt_q, err_cnt_d;

    // Clear takes priority; increments saturate at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_cnt_clr_i) begin
            err_cnt_d = '0;
        end else if (accept && dec_err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    logic unused_err_cnt_clr;
    assign unused_err_cnt_clr = err_cnt_clr_i;
    assign err_cnt_o          = '0;
`endif

endmodule

// File: tb/tb_addr_decode_rt.sv
// Directed bench for addr_decode_rt: decode, priority, backpressure,
// config errors, reset mid-flight and the optional error counter.
module tb_addr_decode_rt;

    localparam int unsigned NI = 3;
    localparam int unsigned NR = 5;
    localparam int unsigned AW = 32;
    localparam int unsigned CW = 2;
    localparam int unsigned IW = 2;
    localparam int unsigned RW = 3;

`ifdef ADDR_DECODE_RT_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [RW-1:0] cfg_rule = '0;
    logic          cfg_en = 1'b0;
    logic [IW-1:0] cfg_idx = '0;
    logic [AW-1:0] cfg_start = '0;
    logic [AW-1:0] cfg_end = '0;
    logic          cfg_err;
    logic          en_def = 1'b0;
    logic [IW-1:0] def_idx = '0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [IW-1:0] rsp_idx;
    logic          rsp_err;
    logic          cnt_clr = 1'b0;
    logic [CW-1:0] err_cnt;

    int n_run  = 0;
    int n_fail = 0;

    addr_decode_rt #(
        .NoIndices  (NI),
        .NoRules    (NR),
        .AddrWidth  (AW),
        .ErrCntWidth(CW)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .cfg_we_i        (cfg_we),
        .cfg_rule_i      (cfg_rule),
        .cfg_en_i        (cfg_en),
        .cfg_idx_i       (cfg_idx),
        .cfg_start_i     (cfg_start),
        .cfg_end_i       (cfg_end),
        .cfg_err_o       (cfg_err),
        .en_default_idx_i(en_def),
        .default_idx_i   (def_idx),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_addr_i      (req_addr),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .rsp_idx_o       (rsp_idx),
        .rsp_dec_error_o (rsp_err),
        .err_cnt_clr_i   (cnt_clr),
        .err_cnt_o       (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [RW-1:0] rule, input logic en,
                      input logic [IW-1:0] idx, input logic [AW-1:0] s,
                      input logic [AW-1:0] e, input logic exp_err);
        cfg_we    = 1'b1;
        cfg_rule  = rule;
        cfg_en    = en;
        cfg_idx   = idx;
        cfg_start = s;
        cfg_end   = e;
        step();
        cfg_we = 1'b0;
        chk("cfg_err", 32'(cfg_err), 32'(exp_err));
    endtask

    task automatic lookup(input string tag, input logic [AW-1:0] a,
                          input logic [IW-1:0] eidx, input logic eerr);
        req_valid = 1'b1;
        req_addr  = a;
        step();
        req_valid = 1'b0;
        chk({tag, ".valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".idx"}, 32'(rsp_idx), 32'(eidx));
        chk({tag, ".err"}, 32'(rsp_err), 32'(eerr));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp_idx", 32'(rsp_idx), 32'd0);
        chk("rst.rsp_err", 32'(rsp_err), 32'd0);
        chk("rst.cfg_err", 32'(cfg_err), 32'd0);
        chk("rst.err_cnt", 32'(err_cnt), 32'd0);
        chk("rst.req_ready", 32'(req_ready), 32'd1);
        rst_n = 1'b1;
        step();

        lookup("empty", 32'h1000, 2'd0, 1'b1);

        wr(3'd0, 1'b1, 2'd1, 32'h1000, 32'h2000, 1'b0);
        lookup("top_in", 32'h1FFF, 2'd1, 1'b0);
        lookup("end_excl", 32'h2000, 2'd0, 1'b1);
        lookup("start_incl", 32'h1000, 2'd1, 1'b0);
        lookup("below", 32'h0FFF, 2'd0, 1'b1);

        wr(3'd0, 1'b1, 2'd1, 32'h0, 32'h100, 1'b0);
        wr(3'd3, 1'b1, 2'd0, 32'h80, 32'h180, 1'b0);
        lookup("prio_ovl", 32'h90, 2'd0, 1'b0);
        lookup("prio_lo", 32'h10, 2'd1, 1'b0);
        lookup("prio_hi", 32'h150, 2'd0, 1'b0);

        wr(3'd1, 1'b1, 2'd2, 32'h3000, 32'h3000, 1'b0);
        lookup("degenerate", 32'h3000, 2'd0, 1'b1);

        en_def  = 1'b1;
        def_idx = 2'd2;
        lookup("default", 32'h7000, 2'd2, 1'b0);
        en_def = 1'b0;

        wr(3'd2, 1'b1, 2'd3, 32'h4000, 32'h5000, 1'b1);
        step();
        chk("cfg_err.pulse_end", 32'(cfg_err), 32'd0);
        lookup("rejected_idx", 32'h4800, 2'd0, 1'b1);
        wr(3'd5, 1'b1, 2'd1, 32'h4000, 32'h5000, 1'b1);
        lookup("rejected_rule", 32'h4800, 2'd0, 1'b1);

        step();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h10;
        step();
        req_addr = 32'h90;
        for (int k = 0; k < 3; k++) begin
            chk("bp.req_ready", 32'(req_ready), 32'd0);
            chk("bp.valid", 32'(rsp_valid), 32'd1);
            chk("bp.idx", 32'(rsp_idx), 32'd1);
            chk("bp.err", 32'(rsp_err), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp.release_ready", 32'(req_ready), 32'd1);
        step();
        chk("b2b0.idx", 32'(rsp_idx), 32'd0);
        chk("b2b0.err", 32'(rsp_err), 32'd0);
        req_addr = 32'h200;
        step();
        chk("b2b1.valid", 32'(rsp_valid), 32'd1);
        chk("b2b1.err", 32'(rsp_err), 32'd1);
        req_addr = 32'h50;
        step();
        chk("b2b2.idx", 32'(rsp_idx), 32'd1);
        chk("b2b2.err", 32'(rsp_err), 32'd0);
        req_valid = 1'b0;
        step();
        chk("drain.valid", 32'(rsp_valid), 32'd0);

        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h10;
        step();
        req_valid = 1'b0;
        chk("midrst.pre_valid", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst.valid", 32'(rsp_valid), 32'd0);
        chk("midrst.idx", 32'(rsp_idx), 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("midrst.req_ready", 32'(req_ready), 32'd1);
        rsp_ready = 1'b1;
        lookup("midrst.cleared", 32'h10, 2'd0, 1'b1);

        cfg_we    = 1'b1;
        cfg_rule  = 3'd0;
        cfg_en    = 1'b1;
        cfg_idx   = 2'd2;
        cfg_start = 32'h1000;
        cfg_end   = 32'h2000;
        req_valid = 1'b1;
        req_addr  = 32'h1500;
        step();
        cfg_we    = 1'b0;
        req_valid = 1'b0;
        chk("wr_acc.err", 32'(rsp_err), 32'd1);
        chk("wr_acc.idx", 32'(rsp_idx), 32'd0);
        chk("wr_acc.cfg_err", 32'(cfg_err), 32'd0);
        lookup("wr_acc.next", 32'h1500, 2'd2, 1'b0);

        step();
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h1500;
        step();
        req_valid = 1'b0;
        wr(3'd0, 1'b1, 2'd1, 32'h1000, 32'h2000, 1'b0);
        chk("pend.valid", 32'(rsp_valid), 32'd1);
        chk("pend.idx", 32'(rsp_idx), 32'd2);
        rsp_ready = 1'b1;
        step();
        chk("pend.drained", 32'(rsp_valid), 32'd0);
        lookup("pend.new", 32'h1500, 2'd1, 1'b0);

        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("cnt.clr0", 32'(err_cnt), 32'd0);
        for (int n = 1; n <= 5; n++) begin
            lookup("cnt.lk", 32'h9000_0000, 2'd0, 1'b1);
            chk("cnt.val", 32'(err_cnt),
                CNT_EN ? ((n > 3) ? 32'd3 : 32'(n)) : 32'd0);
        end
        cnt_clr   = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h9000_0000;
        step();
        cnt_clr   = 1'b0;
        req_valid = 1'b0;
        chk("cnt.clr_wins", 32'(err_cnt), 32'd0);
        chk("cnt.clr_rsp_err", 32'(rsp_err), 32'd1);
        step();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
